// File: rtl/murax_gpio_debouncer.sv
// murax_gpio_debouncer: 2-flop synchroniser plus tick-based debouncer per GPIO input bit.
// Define MURAX_GPIO_DEBOUNCE_EVENTS_EN to build in the rise/fall pulse registers.
module murax_gpio_debouncer #(
   parameter int   WIDTH        = 8,
   parameter int   TICK_DIV     = 12000,
   parameter int   STABLE_TICKS = 10,
   parameter logic RESET_LEVEL  = 1'b0
) (
   input  logic             io_mainClk,
   input  logic             io_asyncReset,
   input  logic [WIDTH-1:0] io_raw,
   output logic [WIDTH-1:0] io_clean,
   output logic [WIDTH-1:0] io_rise,
   output logic [WIDTH-1:0] io_fall
);
   localparam int DW = $clog2(TICK_DIV);
   localparam int CW = $clog2(STABLE_TICKS + 1);
   logic [WIDTH-1:0] sync1_q, sync0_q, clean_q, clean_d;
   logic [DW-1:0]    div_q, div_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic             tick;
   assign tick     = div_q == DW'(TICK_DIV - 1);
   assign div_d    = tick ? '0 : div_q + 1'b1;
   assign io_clean = clean_q;
   // A cycle where the input matches the clean level restarts that channel's count.
   always_comb begin
      clean_d = clean_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync0_q[i] == clean_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick && cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
            clean_d[i] = sync0_q[i];
            cnt_d[i]   = '0;
         end else if (tick) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end
   always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
      if (io_asyncReset) begin
         sync1_q <= {WIDTH{RESET_LEVEL}};
         sync0_q <= {WIDTH{RESET_LEVEL}};
         clean_q <= {WIDTH{RESET_LEVEL}};
         div_q   <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= io_raw;
         sync0_q <= sync1_q;
         clean_q <= clean_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
      end
   end
`ifdef MURAX_GPIO_DEBOUNCE_EVENTS_EN
   logic [WIDTH-1:0] rise_q, fall_q;
   always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
      if (io_asyncReset) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= clean_d & ~clean_q;
         fall_q <= ~clean_d & clean_q;
      end
   end
   assign io_rise = rise_q;
   assign io_fall = fall_q;
`else
   assign io_rise = '0;
   assign io_fall = '0;
`endif
endmodule

// File: tb/tb_murax_gpio_debouncer.sv
// tb_murax_gpio_debouncer: directed and random stimulus checked against a cycle-level reference model.
module tb_murax_gpio_debouncer;
   localparam int TD = 4;
   localparam int ST = 3;
`ifdef MURAX_GPIO_DEBOUNCE_EVENTS_EN
   localparam bit EV = 1'b1;
`else
   localparam bit EV = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] raw = 8'h00;
   logic [7:0] clean, rise, fall;
   int         n_chk = 0;
   int         n_err = 0;
   bit         started = 1'b0;
   murax_gpio_debouncer #(.WIDTH(8), .TICK_DIV(TD), .STABLE_TICKS(ST), .RESET_LEVEL(1'b0)) dut (
      .io_mainClk(clk), .io_asyncReset(rst), .io_raw(raw),
      .io_clean(clean), .io_rise(rise), .io_fall(fall)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   // Reference: the debouncer sees raw delayed by two edges; the clean level flips on the
   // STABLE_TICKS-th tick of an unbroken run in which the delayed input differs from it.
   logic [7:0] hist[$] = '{8'h00, 8'h00};
   logic [7:0] m_clean = 8'h00, m_rise = 8'h00, m_fall = 8'h00;
   int         run [8];
   longint     cyc = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist    = '{8'h00, 8'h00};
         m_clean = 8'h00;
         m_rise  = 8'h00;
         m_fall  = 8'h00;
         cyc     = 0;
         for (int i = 0; i < 8; i++) run[i] = 0;
      end else begin
         logic [7:0] s0, nxt;
         bit tk;
         s0  = hist[0];
         tk  = (cyc % TD) == TD - 1;
         nxt = m_clean;
         for (int i = 0; i < 8; i++) begin
            if (s0[i] == m_clean[i]) run[i] = 0;
            else if (tk) begin
               run[i]++;
               if (run[i] == ST) begin
                  nxt[i] = s0[i];
                  run[i] = 0;
               end
            end
         end
         m_rise  = nxt & ~m_clean;
         m_fall  = ~nxt & m_clean;
         m_clean = nxt;
         cyc++;
         void'(hist.pop_front());
         hist.push_back(raw);
      end
   end
   always @(posedge clk) begin
      #2;
      if (started) begin
         chk("clean", clean, m_clean);
         chk("rise", rise, EV ? m_rise : 8'h00);
         chk("fall", fall, EV ? m_fall : 8'h00);
      end
   end
   task automatic wait_for(input logic [7:0] mask, input logic [7:0] val, output int n);
      n = 0;
      while ((clean & mask) !== val && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask
   initial begin
      int n;
      @(posedge clk);
      started = 1'b1;
      @(negedge clk);
      raw = 8'hFF;
      repeat (5) @(negedge clk);
      chk("rst_held_clean", clean, 8'h00);
      chk("rst_held_rise", rise | fall, 8'h00);
      rst = 1'b0;
      wait_for(8'hFF, 8'hFF, n);
      chk("rst_rel_lat", 32'(n >= 11 && n <= 14), 1);
      chk("rst_rel_rise", rise, EV ? 8'hFF : 8'h00);
      @(negedge clk);
      chk("rst_rel_rise_gone", rise, 8'h00);
      rst = 1'b1;
      raw = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      raw = 8'h01;
      wait_for(8'h01, 8'h01, n);
      chk("bit0_lat", 32'(n >= 11 && n <= 14), 1);
      chk("bit0_rise", rise, EV ? 8'h01 : 8'h00);
      chk("bit0_fall", fall, 8'h00);
      raw = 8'h00;
      repeat (16) @(negedge clk);
      raw = 8'h02;
      repeat (7) @(negedge clk);
      raw = 8'h00;
      repeat (16) @(negedge clk);
      chk("glitch_clean", clean, 8'h00);
      raw = 8'h02;
      repeat (16) @(negedge clk);
      chk("hold_clean", clean, 8'h02);
      raw = 8'h00;
      repeat (16) @(negedge clk);
      raw = 8'hA5;
      wait_for(8'hFF, 8'hA5, n);
      chk("a5_lat", 32'(n >= 11 && n <= 14), 1);
      chk("a5_rise", rise, EV ? 8'hA5 : 8'h00);
      repeat (3) @(negedge clk);
      raw = 8'h5A;
      wait_for(8'hFF, 8'h5A, n);
      chk("5a_lat", 32'(n >= 11 && n <= 14), 1);
      chk("5a_rise", rise, EV ? 8'h5A : 8'h00);
      chk("5a_fall", fall, EV ? 8'hA5 : 8'h00);
      raw = 8'h00;
      repeat (16) @(negedge clk);
      raw = 8'h0F;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_clean", clean, 8'h00);
      chk("midrst_ev", rise | fall, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      wait_for(8'hFF, 8'h0F, n);
      chk("midrst_lat", 32'(n >= 11 && n <= 14), 1);
      repeat (80) begin
         if ($urandom_range(0, 2) == 0) raw = 8'($urandom);
         else raw = raw ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         repeat ($urandom_range(1, 20)) @(negedge clk);
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
